reg_dump_ctrl: RTL and testbench

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/reg_dump_ctrl.sv | 134 +++++++++++++
 tb/tb_reg_dump_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl.sv
// Run/dump controller: resets the processor, lets it run for a fixed number of
// cycles while counting register writes, then streams all 32 registers out.
module reg_dump_ctrl #(
  parameter int CYCLE_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] num_cycles,
  output logic               cpu_reset,
  output logic               cpu_enable,
  input  logic               ctrl_writeEnable,
  input  logic [4:0]         ctrl_writeReg,
  input  logic [4:0]         cpu_readRegA,
  output logic [4:0]         ctrl_readRegA,
  input  logic [31:0]        data_readRegA,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [4:0]         dump_reg,
  output logic [31:0]        dump_data,
  output logic               test_mode,
  output logic               done,
  output logic [CYCLE_W-1:0] cycles,
  output logic [15:0]        write_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CPURST, S_RUN, S_FETCH, S_PRESENT, S_DONE
  } state_t;

  // Output bundle order: {cpu_reset, cpu_enable, test_mode, dump_valid, done}
  function automatic logic [4:0] f_outs(input state_t s);
    case (s)
      S_IDLE:    f_outs = 5'b10000;
      S_CPURST:  f_outs = 5'b10000;
      S_RUN:     f_outs = 5'b01000;
      S_FETCH:   f_outs = 5'b00100;
      S_PRESENT: f_outs = 5'b00110;
      S_DONE:    f_outs = 5'b00101;
      default:   f_outs = 5'b10000;
    endcase
  endfunction

  state_t             r_state;
  logic [4:0]         r_outs;
  logic [CYCLE_W-1:0] r_limit;
  logic [CYCLE_W-1:0] r_cycles;
  logic [15:0]        r_wcount;
  logic [4:0]         r_index;
  logic [4:0]         r_dump_reg;
  logic [31:0]        r_dump_data;

  logic [CYCLE_W-1:0] w_cycles_inc;
  logic               w_count_wr;

  assign w_cycles_inc = r_cycles + 1'b1;
  // Writes to r0 are discarded by the regfile, so they are not counted.
  assign w_count_wr   = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                        (r_wcount != 16'hFFFF);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_outs      <= f_outs(S_IDLE);
      r_limit     <= '0;
      r_cycles    <= '0;
      r_wcount    <= '0;
      r_index     <= '0;
      r_dump_reg  <= '0;
      r_dump_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_CPURST;
            r_outs   <= f_outs(S_CPURST);
            r_limit  <= num_cycles;
            r_cycles <= '0;
            r_wcount <= '0;
            r_index  <= '0;
          end
        end
        S_CPURST: begin
          if (r_limit != '0) begin
            r_state <= S_RUN;
            r_outs  <= f_outs(S_RUN);
          end else begin
            r_state <= S_FETCH;
            r_outs  <= f_outs(S_FETCH);
          end
        end
        S_RUN: begin
          r_cycles <= w_cycles_inc;
          if (w_count_wr) r_wcount <= r_wcount + 16'd1;
          if (w_cycles_inc == r_limit) begin
            r_state <= S_FETCH;
            r_outs  <= f_outs(S_FETCH);
          end
        end
        S_FETCH: begin
          // Regfile read is combinational from the muxed address (= index here).
          r_dump_data <= data_readRegA;
          r_dump_reg  <= r_index;
          r_state     <= S_PRESENT;
          r_outs      <= f_outs(S_PRESENT);
        end
        S_PRESENT: begin
          if (dump_ready) begin
            if (r_index == 5'd31) begin
              r_state <= S_DONE;
              r_outs  <= f_outs(S_DONE);
            end else begin
              r_index <= r_index + 5'd1;
              r_state <= S_FETCH;
              r_outs  <= f_outs(S_FETCH);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_outs  <= f_outs(S_IDLE);
        end
      endcase
    end
  end

  assign {cpu_reset, cpu_enable, test_mode, dump_valid, done} = r_outs;
  assign ctrl_readRegA = test_mode ? r_index : cpu_readRegA;
  assign dump_reg      = r_dump_reg;
  assign dump_data     = r_dump_data;
  assign cycles        = r_cycles;
  assign write_count   = r_wcount;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl: regfile model plus scenario tasks.
module tb_reg_dump_ctrl;

  localparam int CYCLE_W = 10;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [CYCLE_W-1:0] num_cycles;
  logic               cpu_reset;
  logic               cpu_enable;
  logic               ctrl_writeEnable;
  logic [4:0]         ctrl_writeReg;
  logic [4:0]         cpu_readRegA;
  logic [4:0]         ctrl_readRegA;
  logic [31:0]        data_readRegA;
  logic               dump_valid;
  logic               dump_ready;
  logic [4:0]         dump_reg;
  logic [31:0]        dump_data;
  logic               test_mode;
  logic               done;
  logic [CYCLE_W-1:0] cycles;
  logic [15:0]        write_count;

  logic [31:0] rf [32];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign data_readRegA = rf[ctrl_readRegA];

  reg_dump_ctrl #(.CYCLE_W(CYCLE_W)) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_reset(cpu_reset), .cpu_enable(cpu_enable),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .cpu_readRegA(cpu_readRegA), .ctrl_readRegA(ctrl_readRegA),
    .data_readRegA(data_readRegA), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_reg(dump_reg), .dump_data(dump_data),
    .test_mode(test_mode), .done(done), .cycles(cycles),
    .write_count(write_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; num_cycles = 10'd4;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    n_assert++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    n_assert++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_enable got %b exp 0", cpu_enable); end
    n_assert++; if (test_mode !== 1'b0) begin n_fail++; $display("FAIL rst_test_mode got %b exp 0", test_mode); end
    n_assert++; if (dump_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_valid_done got %b%b exp 00", dump_valid, done); end
    n_assert++; if (cycles !== 10'd0 || write_count !== 16'd0) begin n_fail++; $display("FAIL rst_counters got %0d/%0d exp 0/0", cycles, write_count); end
    n_assert++; if (dump_reg !== 5'd0 || dump_data !== 32'd0) begin n_fail++; $display("FAIL rst_dump got %0d/%h exp 0/0", dump_reg, dump_data); end
    n_assert++; if (ctrl_readRegA !== cpu_readRegA) begin n_fail++; $display("FAIL rst_addr_mux got %0d exp %0d", ctrl_readRegA, cpu_readRegA); end
    tick();
    n_assert++; if (cpu_reset !== 1'b1 || cpu_enable !== 1'b0) begin n_fail++; $display("FAIL idle_hold got %b%b exp 10", cpu_reset, cpu_enable); end
  endtask

  // Runs one full start/run/dump sequence; abort_idx >= 0 resets mid-dump.
  task automatic do_sequence(input int n, input bit wr_pat, input int stall_reg,
                             input int abort_idx, input int exp_wc);
    int en_cnt, rst_cnt, k, guard;
    start = 1'b1; num_cycles = CYCLE_W'(n);
    ctrl_writeEnable = wr_pat; ctrl_writeReg = 5'd3;
    tick();
    start = 1'b0;
    n_assert++; if (cycles !== 10'd0 || write_count !== 16'd0) begin n_fail++; $display("FAIL start_clear got %0d/%0d exp 0/0", cycles, write_count); end
    n_assert++; if (done !== 1'b0 || test_mode !== 1'b0 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL start_flags got %b%b%b exp 000", done, test_mode, dump_valid); end
    en_cnt = 0; rst_cnt = 0; k = 0; guard = 0;
    while (test_mode !== 1'b1 && guard < 2000) begin
      if (cpu_reset === 1'b1) rst_cnt++;
      if (cpu_enable === 1'b1) en_cnt++;
      if (cpu_enable === 1'b1) begin
        if (k == 0) begin
          n_assert++; if (ctrl_readRegA !== cpu_readRegA) begin n_fail++; $display("FAIL run_addr_mux got %0d exp %0d", ctrl_readRegA, cpu_readRegA); end
          n_assert++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL run_cpu_reset got %b exp 0", cpu_reset); end
        end
        if (wr_pat && k < 3)      begin ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; end
        else if (wr_pat && k < 7) begin ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; end
        else                      begin ctrl_writeEnable = 1'b0; ctrl_writeReg = 5'd5; end
        start = (k == 2);
        k++;
      end else begin
        ctrl_writeEnable = wr_pat; ctrl_writeReg = 5'd3; start = 1'b0;
      end
      tick(); guard++;
    end
    start = 1'b0;
    ctrl_writeEnable = wr_pat; ctrl_writeReg = 5'd3;
    if (test_mode !== 1'b1) begin
      n_assert++; n_fail++; $display("FAIL run_timeout got test_mode %b exp 1", test_mode);
      return;
    end
    n_assert++; if (rst_cnt != 1) begin n_fail++; $display("FAIL cpurst_len got %0d exp 1", rst_cnt); end
    n_assert++; if (en_cnt != n) begin n_fail++; $display("FAIL run_len got %0d exp %0d", en_cnt, n); end
    n_assert++; if (cycles !== CYCLE_W'(n)) begin n_fail++; $display("FAIL run_cycles got %0d exp %0d", cycles, n); end
    n_assert++; if (write_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL run_wcount got %0d exp %0d", write_count, exp_wc); end

    dump_ready = 1'b0;
    for (int idx = 0; idx < 32; idx++) begin
      guard = 0;
      while (dump_valid !== 1'b1 && guard < 8) begin tick(); guard++; end
      if (dump_valid !== 1'b1) begin
        n_assert++; n_fail++; $display("FAIL dump_timeout idx %0d got valid %b exp 1", idx, dump_valid);
        return;
      end
      n_assert++; if (dump_reg !== 5'(idx)) begin n_fail++; $display("FAIL dump_reg got %0d exp %0d", dump_reg, idx); end
      n_assert++; if (dump_data !== rf[idx]) begin n_fail++; $display("FAIL dump_data idx %0d got %h exp %h", idx, dump_data, rf[idx]); end
      n_assert++; if (ctrl_readRegA !== 5'(idx)) begin n_fail++; $display("FAIL dump_addr got %0d exp %0d", ctrl_readRegA, idx); end
      if (idx == 7) begin
        n_assert++; if (dump_data !== 32'h12345678) begin n_fail++; $display("FAIL dump_r7 got %h exp 12345678", dump_data); end
      end
      if (idx == abort_idx) begin
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        n_assert++; if (cpu_reset !== 1'b1 || cpu_enable !== 1'b0 || test_mode !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl got %b%b%b exp 100", cpu_reset, cpu_enable, test_mode); end
        n_assert++; if (dump_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_valid_done got %b%b exp 00", dump_valid, done); end
        n_assert++; if (cycles !== 10'd0 || write_count !== 16'd0) begin n_fail++; $display("FAIL abort_counters got %0d/%0d exp 0/0", cycles, write_count); end
        n_assert++; if (dump_reg !== 5'd0 || dump_data !== 32'd0) begin n_fail++; $display("FAIL abort_dump got %0d/%h exp 0/0", dump_reg, dump_data); end
        tick(); tick();
        n_assert++; if (cpu_reset !== 1'b1 || cpu_enable !== 1'b0) begin n_fail++; $display("FAIL abort_start_ignored got %b%b exp 10", cpu_reset, cpu_enable); end
        ctrl_writeEnable = 1'b0;
        return;
      end
      if (idx == stall_reg) begin
        repeat (3) begin
          tick();
          n_assert++; if (dump_valid !== 1'b1 || dump_reg !== 5'(idx) || dump_data !== rf[idx]) begin n_fail++; $display("FAIL stall_hold got %b/%0d/%h exp 1/%0d/%h", dump_valid, dump_reg, dump_data, idx, rf[idx]); end
        end
      end
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
      n_assert++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL post_xfer_valid idx %0d got %b exp 0", idx, dump_valid); end
    end
    n_assert++; if (done !== 1'b1 || test_mode !== 1'b1) begin n_fail++; $display("FAIL done_flags got %b%b exp 11", done, test_mode); end
    n_assert++; if (cpu_reset !== 1'b0 || cpu_enable !== 1'b0) begin n_fail++; $display("FAIL done_cpu got %b%b exp 00", cpu_reset, cpu_enable); end
    n_assert++; if (cycles !== CYCLE_W'(n) || write_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL done_counters got %0d/%0d exp %0d/%0d", cycles, write_count, n, exp_wc); end
    tick(); tick();
    n_assert++; if (done !== 1'b1 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL done_hold got %b%b exp 10", done, dump_valid); end
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_run5();
    do_sequence(5, 1'b0, -1, -1, 0);
  endtask

  task automatic test_writes_stall();
    do_sequence(10, 1'b1, 2, -1, 4);
  endtask

  task automatic test_restart_from_done();
    do_sequence(0, 1'b0, -1, -1, 0);
  endtask

  task automatic test_reset_mid_dump();
    do_sequence(3, 1'b0, -1, 10, 0);
    do_sequence(2, 1'b0, -1, -1, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {8'hA5, 8'(i), 16'(i * 37 + 1)};
    rf[7] = 32'h12345678;
    reset = 1'b1; start = 1'b0; num_cycles = '0;
    ctrl_writeEnable = 1'b0; ctrl_writeReg = '0;
    cpu_readRegA = 5'd19; dump_ready = 1'b0;
    test_reset();
    test_run5();
    test_writes_stall();
    test_restart_from_done();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
